// File: rtl/hangman_ctrl.sv
// Game sequencer for a four-letter hangman: latches the secret word, evaluates one
// guess per button press, tracks guessed letters / revealed slots and the life count.
module hangman_ctrl #(
    parameter int START_LIVES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game_i,
    input  logic [19:0] word_in_i,
    input  logic        guess_valid_i,
    input  logic [4:0]  guess_letter_i,
    output logic [4:0]  seg_code0_o,
    output logic [4:0]  seg_code1_o,
    output logic [4:0]  seg_code2_o,
    output logic [4:0]  seg_code3_o,
    output logic [3:0]  score_tens_o,
    output logic [3:0]  score_ones_o,
    output logic [1:0]  status_o,
    output logic        busy_o,
    output logic        hit_o,
    output logic        miss_o,
    output logic        repeat_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    localparam logic [6:0] START_L    = 7'(START_LIVES);
    localparam logic [3:0] START_TENS = 4'(START_LIVES / 10);
    localparam logic [3:0] START_ONES = 4'(START_LIVES % 10);
    localparam logic [4:0] CODE_DASH  = 5'd31;
    localparam logic [4:0] CODE_Z     = 5'd25;

    state_t      state_q, state_d;
    logic [19:0] word_q, word_d;
    logic [25:0] guessed_q, guessed_d;
    logic [3:0]  revealed_q, revealed_d;
    logic [6:0]  lives_q, lives_d;
    logic [4:0]  letter_q, letter_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic        repeat_q, repeat_d;

    logic [3:0]  match;
    logic [3:0]  load_revealed;
    logic [4:0]  seg_code [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            assign match[gi]         = (word_q[5*gi +: 5] == letter_q);
            // Codes outside a..z can never be guessed, so they are shown from the start.
            assign load_revealed[gi] = (word_in_i[5*gi +: 5] > CODE_Z);
            assign seg_code[gi]      = (revealed_q[gi] || state_q == ST_LOSE)
                                       ? word_q[5*gi +: 5] : CODE_DASH;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        guessed_d  = guessed_q;
        revealed_d = revealed_q;
        lives_d    = lives_q;
        letter_d   = letter_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        repeat_d   = 1'b0;

        if (new_game_i) begin
            word_d     = word_in_i;
            guessed_d  = '0;
            revealed_d = load_revealed;
            lives_d    = START_L;
            state_d    = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (guess_valid_i && guess_letter_i <= CODE_Z) begin
                        letter_d = guess_letter_i;
                        state_d  = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (guessed_q[letter_q]) begin
                        repeat_d = 1'b1;
                    end else begin
                        guessed_d[letter_q] = 1'b1;
                        if (|match) begin
                            revealed_d = revealed_q | match;
                            hit_d      = 1'b1;
                        end else begin
                            if (lives_q != 7'd0) begin
                                lives_d = lives_q - 7'd1;
                            end
                            miss_d = 1'b1;
                        end
                    end
                    if (&revealed_d) begin
                        state_d = ST_WIN;
                    end else if (lives_d == 7'd0) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                default: ;
            endcase
        end

        tens_d = 4'(lives_d / 7'd10);
        ones_d = 4'(lives_d % 7'd10);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_q     <= '0;
            guessed_q  <= '0;
            revealed_q <= '0;
            lives_q    <= START_L;
            letter_q   <= '0;
            tens_q     <= START_TENS;
            ones_q     <= START_ONES;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            guessed_q  <= guessed_d;
            revealed_q <= revealed_d;
            lives_q    <= lives_d;
            letter_q   <= letter_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            repeat_q   <= repeat_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_PLAY, ST_CHECK: status_o = 2'b01;
            ST_WIN:            status_o = 2'b10;
            ST_LOSE:           status_o = 2'b11;
            default:           status_o = 2'b00;
        endcase
    end

    assign seg_code0_o  = seg_code[0];
    assign seg_code1_o  = seg_code[1];
    assign seg_code2_o  = seg_code[2];
    assign seg_code3_o  = seg_code[3];
    assign score_tens_o = tens_q;
    assign score_ones_o = ones_q;
    assign busy_o       = (state_q == ST_CHECK);
    assign hit_o        = hit_q;
    assign miss_o       = miss_q;
    assign repeat_o     = repeat_q;

endmodule

// File: tb/tb_hangman_ctrl.sv
// Directed bench for hangman_ctrl: hit/miss/repeat, duplicate letters, win, lose,
// collisions with new_game / guess_valid, and asynchronous reset mid-guess.
module tb_hangman_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        new_game_i = 1'b0;
    logic [19:0] word_in_i = '0;
    logic        guess_valid_i = 1'b0;
    logic [4:0]  guess_letter_i = '0;
    logic [4:0]  seg_code0_o, seg_code1_o, seg_code2_o, seg_code3_o;
    logic [3:0]  score_tens_o, score_ones_o;
    logic [1:0]  status_o;
    logic        busy_o, hit_o, miss_o, repeat_o;

    int tests_run = 0;
    int tests_failed = 0;

    hangman_ctrl #(.START_LIVES(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_game_i    (new_game_i),
        .word_in_i     (word_in_i),
        .guess_valid_i (guess_valid_i),
        .guess_letter_i(guess_letter_i),
        .seg_code0_o   (seg_code0_o),
        .seg_code1_o   (seg_code1_o),
        .seg_code2_o   (seg_code2_o),
        .seg_code3_o   (seg_code3_o),
        .score_tens_o  (score_tens_o),
        .score_ones_o  (score_ones_o),
        .status_o      (status_o),
        .busy_o        (busy_o),
        .hit_o         (hit_o),
        .miss_o        (miss_o),
        .repeat_o      (repeat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] mkword(input int s0, input int s1, input int s2, input int s3);
        return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    task automatic start_game(input logic [19:0] w);
        new_game_i = 1'b1;
        word_in_i  = w;
        tick();
        new_game_i = 1'b0;
    endtask

    // Drives one guess and stops right after the CHECK cycle, when outcomes are visible.
    task automatic guess(input int l);
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'(l);
        tick();
        guess_valid_i  = 1'b0;
        tick();
    endtask

    task automatic check_segs(input string tag, input int s0, input int s1, input int s2, input int s3);
        check({tag, "_seg0"}, 32'(seg_code0_o), 32'(s0));
        check({tag, "_seg1"}, 32'(seg_code1_o), 32'(s1));
        check({tag, "_seg2"}, 32'(seg_code2_o), 32'(s2));
        check({tag, "_seg3"}, 32'(seg_code3_o), 32'(s3));
    endtask

    task automatic check_pulses(input string tag, input int h, input int m, input int r);
        check({tag, "_hit"},    32'(hit_o),    32'(h));
        check({tag, "_miss"},   32'(miss_o),   32'(m));
        check({tag, "_repeat"}, 32'(repeat_o), 32'(r));
    endtask

    task automatic check_score(input string tag, input int t, input int o);
        check({tag, "_tens"}, 32'(score_tens_o), 32'(t));
        check({tag, "_ones"}, 32'(score_ones_o), 32'(o));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_status", 32'(status_o), 0);
        check_segs("rst", 31, 31, 31, 31);
        check_score("rst", 1, 0);
        check("rst_busy", 32'(busy_o), 0);
        check_pulses("rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // Hit on "abcd"
        start_game(mkword(0, 1, 2, 3));
        check("ng_status", 32'(status_o), 1);
        check_segs("ng", 31, 31, 31, 31);
        check_score("ng", 1, 0);
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'd1;
        tick();
        guess_valid_i  = 1'b0;
        check("chk_busy", 32'(busy_o), 1);
        check_pulses("chk", 0, 0, 0);
        check("chk_status", 32'(status_o), 1);
        tick();
        check_pulses("hit1", 1, 0, 0);
        check_segs("hit1", 31, 1, 31, 31);
        check_score("hit1", 1, 0);
        check("hit1_status", 32'(status_o), 1);
        check("hit1_busy", 32'(busy_o), 0);
        tick();
        check_pulses("hit1_after", 0, 0, 0);

        // Miss, repeat, illegal code
        guess(25);
        check_pulses("miss25", 0, 1, 0);
        check_score("miss25", 0, 9);
        guess(25);
        check_pulses("rep25", 0, 0, 1);
        check_score("rep25", 0, 9);
        guess(27);
        check_pulses("ill27", 0, 0, 0);
        check("ill27_busy", 32'(busy_o), 0);
        check("ill27_status", 32'(status_o), 1);

        // guess_valid during CHECK is dropped
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'd2;
        tick();
        guess_letter_i = 5'd3;
        tick();
        guess_valid_i  = 1'b0;
        check_pulses("drop_first", 1, 0, 0);
        check_segs("drop", 31, 1, 2, 31);
        tick();
        check_pulses("drop_second", 0, 0, 0);
        check("drop_busy", 32'(busy_o), 0);

        // Duplicate letters and win on "noon"
        start_game(mkword(13, 14, 14, 13));
        guess(14);
        check_pulses("noon14", 1, 0, 0);
        check_segs("noon14", 31, 14, 14, 31);
        guess(13);
        check_pulses("noon13", 1, 0, 0);
        check("win_status", 32'(status_o), 2);
        check_segs("win", 13, 14, 14, 13);
        guess(0);
        check_pulses("win_ign", 0, 0, 0);
        check("win_ign_busy", 32'(busy_o), 0);
        check("win_ign_status", 32'(status_o), 2);

        // Lose after ten distinct misses
        start_game(mkword(0, 1, 2, 3));
        for (int i = 0; i < 9; i++) guess(4 + i);
        check("lose9_status", 32'(status_o), 1);
        check_score("lose9", 0, 1);
        guess(13);
        check_pulses("lose10", 0, 1, 0);
        check("lose_status", 32'(status_o), 3);
        check_score("lose", 0, 0);
        check_segs("lose", 0, 1, 2, 3);
        guess(14);
        check_pulses("lose_ign", 0, 0, 0);
        check("lose_ign_status", 32'(status_o), 3);

        // new_game and guess_valid together: guess dropped, mask cleared
        start_game(mkword(0, 1, 2, 3));
        guess(4);
        check_score("pre_coll", 0, 9);
        new_game_i     = 1'b1;
        word_in_i      = mkword(0, 1, 2, 3);
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'd4;
        tick();
        new_game_i    = 1'b0;
        guess_valid_i = 1'b0;
        check("coll_status", 32'(status_o), 1);
        check("coll_busy", 32'(busy_o), 0);
        check_score("coll", 1, 0);
        tick();
        check_pulses("coll", 0, 0, 0);
        guess(4);
        check_pulses("coll_cleared", 0, 1, 0);
        check_score("coll_cleared", 0, 9);

        // new_game during CHECK discards the pending guess
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'd5;
        tick();
        guess_valid_i = 1'b0;
        new_game_i    = 1'b1;
        tick();
        new_game_i = 1'b0;
        check_pulses("ngchk", 0, 0, 0);
        check("ngchk_status", 32'(status_o), 1);
        check("ngchk_busy", 32'(busy_o), 0);
        check_score("ngchk", 1, 0);
        tick();
        check_pulses("ngchk_after", 0, 0, 0);

        // Slot code above z is shown from load
        start_game(mkword(30, 1, 2, 3));
        check_segs("raw", 30, 31, 31, 31);

        // Asynchronous reset mid-CHECK
        guess(1);
        guess_valid_i  = 1'b1;
        guess_letter_i = 5'd9;
        tick();
        guess_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_status", 32'(status_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        check_segs("arst", 31, 31, 31, 31);
        check_score("arst", 1, 0);
        check_pulses("arst", 0, 0, 0);
        tick();
        check_pulses("arst_edge", 0, 0, 0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hangman_ctrl.md
# hangman_ctrl

Game sequencer for the four-letter hangman display. It latches a secret word and accepts one guessed letter per debounced button press. It tracks guessed letters and revealed slots, and counts down the remaining lives. It drives the per-digit letter codes consumed by the on-board seven-segment scanner and the two BCD score digits consumed by the external PMOD score display.

## Interface
- START_LIVES, default 10: lives at game start; legal range 1..99.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- new_game  in  1  single-cycle pulse; latches word_in and starts a game.
- word_in  in  20  secret word. Slot k is word_in[5k+4:5k], k = 0..3. Slot k drives display digit k. Letter codes are 0 = a … 25 = z.
- guess_valid  in  1  single-cycle pulse qualifying guess_letter.
- guess_letter  in  5  guessed letter code, 0..25.
- seg_code0..seg_code3  out  5 each  letter code per digit. 31 means unrevealed, and the display renders it as '-'.
- score_tens, score_ones  out  4 each  BCD of remaining lives.
- status  out  2  game state: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- busy  out  1  high while a guess is being evaluated.
- hit, miss, repeat  out  1 each  single-cycle outcome pulses.

## Operation
- **States:** IDLE, PLAY, CHECK, WIN, LOSE. Reset enters IDLE.
- **new_game:** accepted in every state, including CHECK.
  - Latches the word.
  - Clears the 26-bit guessed mask and the 4-bit revealed mask.
  - Sets lives to START_LIVES.
  - Forces all seg_code to 31 and enters PLAY.
  - A slot loaded with a code > 25 is marked revealed at load and displays its raw code.
- **new_game priority:** wins over guess_valid in the same cycle; the guess is dropped.
- **guess_valid in PLAY:**
  - If guess_letter ≤ 25, latch it and go to CHECK.
  - Otherwise ignore it, with no pulse and no state change.
- **guess_valid outside PLAY:** ignored in IDLE, CHECK, WIN and LOSE.
- **CHECK:** always one cycle; exactly one outcome applies.
  - **Repeat:** the letter's bit in the guessed mask is already set. Pulse repeat; lives unchanged.
  - **Hit:** the letter is not in the mask and matches ≥1 slot. Set the bit, reveal every matching slot at once, pulse hit.
  - **Miss:** the letter is not in the mask and matches no slot. Set the bit, decrement lives by 1, pulse miss.
- **Next state after CHECK:**
  - WIN if all four slots are revealed.
  - Else LOSE if lives = 0.
  - Else PLAY.
- **WIN and LOSE:** terminal until new_game or rst.
  - On entering LOSE, all four seg_code show the full word.
  - In WIN, the full word is already visible.
- **Lives arithmetic:** 7-bit unsigned, never decremented below 0. score_tens = lives / 10, score_ones = lives % 10, both registered.

## Timing
- **Reset values (asynchronous):**
  - status = 00, busy = 0, hit = miss = repeat = 0.
  - seg_code0..3 = 31.
  - lives = START_LIVES; score digits show START_LIVES (1/0 at default).
  - Word and both masks cleared.
- **new_game at edge N:**
  - status = 01 after N.
  - seg_code = 31 and score digits reset after N.
- **guess_valid at edge N (in PLAY):**
  - CHECK and busy = 1 after N.
  - After N+1: seg_code, lives, score digits, status and the single outcome pulse all update together; busy = 0.
  - The pulse lasts exactly one cycle.
- **Guess throughput:** one guess per 2 cycles maximum. A guess_valid at N+1 is dropped.
- **rst mid-CHECK:** no outcome pulse is emitted.
- **new_game mid-CHECK:** the pending guess is discarded, no pulse is emitted, and the game restarts.

## Test plan
- **Reset:** assert rst mid-run -> status 00, seg_code all 31, score 1/0, busy/hit/miss/repeat 0, with no clock edge required.
- **Hit:** new_game with word "abcd" (0,1,2,3), then guess 1 -> two cycles later hit pulse for one cycle, seg_code1 = 1, others 31, score 1/0, status 01.
- **Miss and repeat:** on "abcd", guess 25 -> miss pulse, score 0/9. Guess 25 again -> repeat pulse, score stays 0/9. Guess 27 -> no pulse, state unchanged.
- **Duplicate letters and win:** word "noon" (13,14,14,13). Guess 14 -> seg_code1 = seg_code2 = 14. Guess 13 -> hit, status 10. A further guess -> ignored.
- **Lose:** with START_LIVES = 10 on "abcd", issue ten distinct misses -> status 11 after the tenth, score 0/0, seg_code0..3 = 0,1,2,3. A further guess_valid -> ignored.
- **Collisions:**
  - new_game and guess_valid in the same cycle -> PLAY, no pulse, masks clear.
  - new_game during CHECK -> no pulse, lives back to 10.
  - guess_valid during CHECK -> dropped, only one pulse emitted.
